// File: rtl/aliens_pkg.sv
// Shared definitions for the Aliens CPU-side memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aliens_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROM_WAIT = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // CPU address map region bases
  localparam logic [15:0] PAL_BASE     = 16'h0000;
  localparam logic [15:0] WORK_END     = 16'h1FFF;
  localparam logic [15:0] BANKWIN_BASE = 16'h2000;
  localparam logic [15:0] VID_BASE     = 16'h4000;
  localparam logic [15:0] IO_BASE      = 16'h5C00;
  localparam logic [15:0] INIT_BASE    = 16'h7800;
  localparam logic [15:0] PROG_BASE    = 16'h8000;

  // Bankswitch register (setlines) bit positions
  localparam int SL_BANK_LSB = 0;
  localparam int SL_BANK_MSB = 4;
  localparam int SL_WOCO     = 5;
  localparam int SL_INIT     = 6;

  // ROM chip identifiers on the fetch port
  localparam logic ROM_CHIP_PROG = 1'b0;
  localparam logic ROM_CHIP_BANK = 1'b1;

  // Byte returned to the CPU when no valid ROM data is available
  localparam logic [7:0] ROM_DOUT_IDLE = 8'hFF;

  // Cache tag: a fetch is identified by chip plus ROM address
  function automatic logic [18:0] rom_tag(input logic chip, input logic [17:0] addr);
    return {chip, addr};
  endfunction

endpackage

// File: rtl/aliens_addr_decode.sv
// Combinational CPU address map decode plus ROM fetch address/chip formation.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module aliens_addr_decode
  import aliens_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [4:0]  bank,
  input  logic        woco,
  input  logic        init,
  output logic        sel_pal,
  output logic        sel_work,
  output logic        sel_bank,
  output logic        sel_prog,
  output logic        sel_vid,
  output logic        sel_io,
  output logic        sel_init,
  output logic [17:0] rom_addr,
  output logic        rom_chip
);

  logic low_page;
  logic bank_win;
  logic prog_fix;

  // Region decode; the lowest 1 KB page is palette or work RAM depending on woco
  always_comb begin
    low_page = (addr[15:10] == PAL_BASE[15:10]);
    bank_win = (addr[15:13] == BANKWIN_BASE[15:13]);
    prog_fix = (addr[15] == PROG_BASE[15]);

    sel_pal  = low_page & woco;
    sel_work = (low_page & ~woco) | ((addr <= WORK_END) & ~low_page);
    // bank[4] redirects the banked window from the bank ROM into the upper half of prog ROM
    sel_bank = bank_win & ~bank[4];
    sel_prog = prog_fix | (bank_win & bank[4]);
    // io sits inside the video window; both selects fire together there
    sel_vid  = (addr[15:14] == VID_BASE[15:14]);
    sel_io   = (addr[15:10] == IO_BASE[15:10]);
    sel_init = init & (addr[15:11] == INIT_BASE[15:11]);
  end

  // ROM fetch address: fixed prog space maps straight, banked window uses bank[3:0] as page
  always_comb begin
    if (prog_fix) begin
      rom_addr = {3'b000, addr[14:0]};
      rom_chip = ROM_CHIP_PROG;
    end else begin
      rom_addr = {bank[4], bank[3:0], addr[12:0]};
      rom_chip = bank[4] ? ROM_CHIP_PROG : ROM_CHIP_BANK;
    end
  end

endmodule

// File: rtl/aliens_mem_ctrl.sv
// CPU-side memory controller: bankswitch register, registered chip selects, ROM fetch sequencing.
// Latency: selects and rom_req one cycle after AS low; cache hit returns data on that same cycle.
// Backpressure: cpu_wait stalls the CPU until rom_ack or the TIMEOUT-cycle forced release.
module aliens_mem_ctrl
  import aliens_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_as_n,
  input  logic        cpu_rw,
  input  logic        setlines_we,
  input  logic [7:0]  setlines_d,
  output logic        cs_work,
  output logic        cs_pal,
  output logic        cs_bank,
  output logic        cs_prog,
  output logic        cs_vid,
  output logic        cs_io,
  output logic        cs_init,
  output logic        cpu_wait,
  output logic        rom_req,
  input  logic        rom_ack,
  output logic        rom_chip,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  rom_dout,
  output logic        rom_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Bankswitch register
  logic [4:0] bank_q;
  logic       woco_q;
  logic       init_q;

  // Decode of the live CPU address against the current register
  logic        dec_pal, dec_work, dec_bank, dec_prog, dec_vid, dec_io, dec_init;
  logic [17:0] dec_rom_addr;
  logic        dec_rom_chip;

  // Sequencer
  state_t          state_q, state_nxt;
  logic [CW-1:0]   tmo_cnt_q;
  logic            abort_q;

  // Single-entry read cache
  logic        cache_vld_q;
  logic [18:0] cache_tag_q;
  logic [7:0]  cache_dat_q;

  // Control strobes from the output process
  logic rom_rd;
  logic cache_hit;
  logic tmo_hit;
  logic start_acc;
  logic start_fetch;
  logic take_hit;
  logic take_ack;
  logic take_tmo;
  logic clr_cs;

  // Bit 7 of the setlines byte has no function in this block
  logic unused_sl7;
  assign unused_sl7 = setlines_d[7];

  aliens_addr_decode u_decode (
    .addr     (cpu_addr),
    .bank     (bank_q),
    .woco     (woco_q),
    .init     (init_q),
    .sel_pal  (dec_pal),
    .sel_work (dec_work),
    .sel_bank (dec_bank),
    .sel_prog (dec_prog),
    .sel_vid  (dec_vid),
    .sel_io   (dec_io),
    .sel_init (dec_init),
    .rom_addr (dec_rom_addr),
    .rom_chip (dec_rom_chip)
  );

  // Access classification, cache lookup and timeout terminal count
  always_comb begin
    rom_rd    = cpu_rw & (dec_bank | dec_prog);
    cache_hit = CACHE_EN & cache_vld_q &
                (cache_tag_q == rom_tag(dec_rom_chip, dec_rom_addr));
    tmo_hit   = (tmo_cnt_q == CW'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; a new access is only recognised from IDLE
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cpu_as_n) begin
          state_nxt = (rom_rd && !cache_hit) ? ST_ROM_WAIT : ST_HOLD;
        end
      end
      ST_ROM_WAIT: begin
        if (rom_ack) begin
          // CPU already left the cycle: skip HOLD and drop the selects at once
          state_nxt = (abort_q || cpu_as_n) ? ST_IDLE : ST_HOLD;
        end else if (tmo_hit) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cpu_as_n) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/control strobes derived from state and inputs
  always_comb begin
    start_acc   = (state_q == ST_IDLE) && !cpu_as_n;
    start_fetch = start_acc && rom_rd && !cache_hit;
    take_hit    = start_acc && rom_rd && cache_hit;
    take_ack    = (state_q == ST_ROM_WAIT) && rom_ack;
    take_tmo    = (state_q == ST_ROM_WAIT) && !rom_ack && tmo_hit;
    clr_cs      = ((state_q == ST_HOLD) && cpu_as_n) ||
                  (take_ack && (abort_q || cpu_as_n));
  end

  // Bankswitch register write, accepted in any state
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 5'd0;
      woco_q <= 1'b0;
      init_q <= 1'b0;
    end else if (setlines_we) begin
      bank_q <= setlines_d[SL_BANK_MSB:SL_BANK_LSB];
      woco_q <= setlines_d[SL_WOCO];
      init_q <= setlines_d[SL_INIT];
    end
  end

  // Chip selects and latched fetch address; cs_init tracks the live address every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_pal   <= 1'b0;
      cs_work  <= 1'b0;
      cs_bank  <= 1'b0;
      cs_prog  <= 1'b0;
      cs_vid   <= 1'b0;
      cs_io    <= 1'b0;
      cs_init  <= 1'b0;
      rom_addr <= 18'd0;
      rom_chip <= ROM_CHIP_PROG;
    end else begin
      cs_init <= dec_init;
      if (start_acc) begin
        cs_pal   <= dec_pal;
        cs_work  <= dec_work;
        cs_bank  <= dec_bank;
        cs_prog  <= dec_prog;
        cs_vid   <= dec_vid;
        cs_io    <= dec_io;
        // Latched here so a later bankswitch write cannot disturb an in-flight fetch
        rom_addr <= dec_rom_addr;
        rom_chip <= dec_rom_chip;
      end else if (clr_cs) begin
        cs_pal  <= 1'b0;
        cs_work <= 1'b0;
        cs_bank <= 1'b0;
        cs_prog <= 1'b0;
        cs_vid  <= 1'b0;
        cs_io   <= 1'b0;
      end
    end
  end

  // Fetch handshake, CPU stall, returned byte and timeout error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_req  <= 1'b0;
      cpu_wait <= 1'b0;
      rom_dout <= ROM_DOUT_IDLE;
      rom_err  <= 1'b0;
    end else begin
      rom_err <= take_tmo;
      if (start_fetch) begin
        rom_req  <= 1'b1;
        cpu_wait <= 1'b1;
      end
      if (take_hit) begin
        rom_dout <= cache_dat_q;
      end
      if (take_ack) begin
        rom_req  <= 1'b0;
        cpu_wait <= 1'b0;
        rom_dout <= rom_data;
      end else if (take_tmo) begin
        rom_req  <= 1'b0;
        cpu_wait <= 1'b0;
        rom_dout <= ROM_DOUT_IDLE;
      end
    end
  end

  // Timeout counter restarts at zero on every entry to ROM_WAIT
  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_ROM_WAIT)) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
  end

  // Remember that AS went high mid-fetch so the ack returns straight to IDLE
  always_ff @(posedge clk) begin
    if (reset || start_fetch) begin
      abort_q <= 1'b0;
    end else if ((state_q == ST_ROM_WAIT) && cpu_as_n) begin
      abort_q <= 1'b1;
    end
  end

  // Cache fill on a completed handshake only; timeouts leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
      cache_tag_q <= 19'd0;
      cache_dat_q <= 8'd0;
    end else if (take_ack && CACHE_EN) begin
      cache_vld_q <= 1'b1;
      cache_tag_q <= rom_tag(rom_chip, rom_addr);
      cache_dat_q <= rom_data;
    end
  end

endmodule

// File: tb/tb_aliens_mem_ctrl.sv
module tb_aliens_mem_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_as_n = 1'b1;
  logic        cpu_rw = 1'b1;
  logic        setlines_we = 1'b0;
  logic [7:0]  setlines_d = 8'h00;
  logic        cs_work, cs_pal, cs_bank, cs_prog, cs_vid, cs_io, cs_init;
  logic        cpu_wait, rom_req, rom_chip, rom_err;
  logic        rom_ack = 1'b0;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  rom_dout;

  aliens_mem_ctrl #(.TIMEOUT(TMO), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .setlines_we(setlines_we), .setlines_d(setlines_d),
    .cs_work(cs_work), .cs_pal(cs_pal), .cs_bank(cs_bank), .cs_prog(cs_prog),
    .cs_vid(cs_vid), .cs_io(cs_io), .cs_init(cs_init), .cpu_wait(cpu_wait),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_chip(rom_chip), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_dout(rom_dout), .rom_err(rom_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0]  m_bank = 5'd0;
  logic        m_woco = 1'b0;
  logic        m_init = 1'b0;
  logic        m_cv = 1'b0;
  logic [18:0] m_ckey = 19'd0;
  logic [7:0]  m_cdat = 8'd0;
  logic [7:0]  m_dout = 8'hFF;

  // {pal, work, bank, prog, vid, io}
  logic [5:0] cs_vec;
  assign cs_vec = {cs_pal, cs_work, cs_bank, cs_prog, cs_vid, cs_io};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected selects from address ranges
  function automatic logic [5:0] exp_cs(input logic [15:0] a, input logic [4:0] bk, input logic wo);
    logic pal, work, bnk, prog, vid, io, banked;
    banked = (a >= 16'h2000) && (a < 16'h4000);
    pal  = (a < 16'h0400) && wo;
    work = ((a < 16'h0400) && !wo) || ((a >= 16'h0400) && (a < 16'h2000));
    bnk  = banked && (bk < 5'd16);
    prog = (a >= 16'h8000) || (banked && (bk >= 5'd16));
    vid  = (a >= 16'h4000) && (a < 16'h8000);
    io   = (a >= 16'h5C00) && (a < 16'h6000);
    return {pal, work, bnk, prog, vid, io};
  endfunction

  // Expected {chip, rom address}
  function automatic logic [18:0] exp_rom(input logic [15:0] a, input logic [4:0] bk);
    int base;
    if (a >= 16'h8000) return {1'b0, 18'(int'(a) - 32'h8000)};
    base = int'(bk % 16) * 32'h2000 + (int'(a) - 32'h2000);
    if (bk >= 5'd16) return {1'b0, 18'(32'h20000 + base)};
    return {1'b1, 18'(base)};
  endfunction

  task automatic set_lines(input logic [7:0] d);
    setlines_d = d;
    setlines_we = 1'b1;
    tick;
    setlines_we = 1'b0;
    m_bank = d[4:0];
    m_woco = d[5];
    m_init = d[6];
  endtask

  // One CPU access; dly = ack delay in cycles, 0 = never acknowledge
  task automatic do_read(input logic [15:0] a, input logic rw, input int dly, input logic [7:0] dat);
    logic [5:0]  ecs;
    logic [18:0] key;
    logic        is_rom, hit;
    int          n, guard;
    ecs = exp_cs(a, m_bank, m_woco);
    key = exp_rom(a, m_bank);
    is_rom = rw && (ecs[3] || ecs[2]);
    hit = is_rom && m_cv && (m_ckey == key);
    cpu_addr = a;
    cpu_rw = rw;
    cpu_as_n = 1'b0;
    tick;
    check("cs_vec", cs_vec, ecs);
    check("cs_init", cs_init, m_init && (a >= 16'h7800) && (a < 16'h8000));
    check("rom_req", rom_req, is_rom && !hit);
    check("cpu_wait", cpu_wait, is_rom && !hit);
    if (is_rom && !hit) begin
      check("rom_key", {rom_chip, rom_addr}, key);
      n = 1;
      if (dly > 0) begin
        repeat (dly - 1) begin
          tick;
          if (cpu_wait) n++;
        end
        rom_data = dat;
        rom_ack = 1'b1;
        tick;
        rom_ack = 1'b0;
        rom_data = 8'($urandom);
        check("wait_cycles", n, dly);
        check("req_drop", rom_req, 1'b0);
        check("wait_drop", cpu_wait, 1'b0);
        m_dout = dat;
        m_cv = 1'b1;
        m_ckey = key;
        m_cdat = dat;
      end else begin
        guard = 0;
        while (rom_req === 1'b1 && guard < 200) begin
          tick;
          guard++;
          if (rom_req) n++;
        end
        check("tmo_cycles", n, TMO);
        check("rom_err_pulse", rom_err, 1'b1);
        check("tmo_wait_drop", cpu_wait, 1'b0);
        // Late ack while holding must be ignored
        rom_data = 8'h77;
        rom_ack = 1'b1;
        tick;
        rom_ack = 1'b0;
        check("rom_err_clear", rom_err, 1'b0);
        check("late_ack_req", rom_req, 1'b0);
        m_dout = 8'hFF;
      end
    end else if (hit) begin
      m_dout = m_cdat;
    end
    check("rom_dout", rom_dout, m_dout);
    cpu_as_n = 1'b1;
    tick;
    check("cs_release", cs_vec, 6'd0);
  endtask

  initial begin
    logic [15:0] last_a;
    logic [15:0] ra;
    // Reset state
    tick;
    tick;
    check("rst_cs", cs_vec, 6'd0);
    check("rst_cs_init", cs_init, 1'b0);
    check("rst_wait", cpu_wait, 1'b0);
    check("rst_req", rom_req, 1'b0);
    check("rst_err", rom_err, 1'b0);
    check("rst_addr", {rom_chip, rom_addr}, 19'd0);
    check("rst_dout", rom_dout, 8'hFF);
    reset = 1'b0;
    tick;

    // Palette with woco
    set_lines(8'h25);
    do_read(16'h0010, 1'b1, 1, 8'h00);
    // Bank ROM fetch, then cache hit
    set_lines(8'h03);
    do_read(16'h2ABC, 1'b1, 5, 8'h5A);
    do_read(16'h2ABC, 1'b1, 5, 8'h00);
    // bank[4] redirects into prog ROM
    set_lines(8'h13);
    do_read(16'h2ABC, 1'b1, 3, 8'h33);
    // Timeout, then refetch
    do_read(16'h8001, 1'b1, 0, 8'h00);
    do_read(16'h8001, 1'b1, 2, 8'h81);
    // ROM-region write: no fetch, cache untouched
    do_read(16'h8001, 1'b0, 1, 8'h00);
    do_read(16'h8001, 1'b1, 1, 8'h00);
    // io overlaps vid
    do_read(16'h5C20, 1'b1, 1, 8'h00);
    // cs_init from live address with AS high
    set_lines(8'h40);
    cpu_addr = 16'h7900;
    tick;
    check("cs_init_live", cs_init, 1'b1);
    check("cs_init_no_as", cs_vec, 6'd0);
    cpu_addr = 16'h7000;
    tick;
    check("cs_init_off", cs_init, 1'b0);

    // AS rises mid-fetch: handshake completes, back to IDLE, cache loaded
    cpu_addr = 16'h9000;
    cpu_rw = 1'b1;
    cpu_as_n = 1'b0;
    tick;
    check("abort_req", rom_req, 1'b1);
    tick;
    cpu_as_n = 1'b1;
    tick;
    tick;
    check("abort_req_held", rom_req, 1'b1);
    rom_data = 8'hC3;
    rom_ack = 1'b1;
    tick;
    rom_ack = 1'b0;
    check("abort_cs", cs_vec, 6'd0);
    check("abort_req_drop", rom_req, 1'b0);
    check("abort_wait", cpu_wait, 1'b0);
    check("abort_dout", rom_dout, 8'hC3);
    m_dout = 8'hC3;
    m_cv = 1'b1;
    m_ckey = exp_rom(16'h9000, m_bank);
    m_cdat = 8'hC3;
    do_read(16'h9000, 1'b1, 3, 8'h00);

    // Randomised accesses against the model
    last_a = 16'h9000;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) set_lines(8'($urandom));
      if ($urandom_range(0, 2) == 0) ra = last_a;
      else ra = 16'($urandom);
      do_read(ra, $urandom_range(0, 3) != 0, int'($urandom_range(1, 8)), 8'($urandom));
      last_a = ra;
    end

    // Reset during ROM_WAIT
    do_read(16'h8765, 1'b1, 2, 8'h12);
    cpu_addr = 16'hA55A;
    cpu_rw = 1'b1;
    cpu_as_n = 1'b0;
    tick;
    check("pre_rst_req", rom_req, 1'b1);
    tick;
    reset = 1'b1;
    cpu_as_n = 1'b1;
    tick;
    check("midrst_req", rom_req, 1'b0);
    check("midrst_wait", cpu_wait, 1'b0);
    check("midrst_cs", cs_vec, 6'd0);
    check("midrst_cs_init", cs_init, 1'b0);
    check("midrst_dout", rom_dout, 8'hFF);
    reset = 1'b0;
    m_bank = 5'd0;
    m_woco = 1'b0;
    m_init = 1'b0;
    m_cv = 1'b0;
    m_dout = 8'hFF;
    tick;
    do_read(16'hA55A, 1'b1, 4, 8'h6B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aliens_mem_ctrl.md
Name: aliens_mem_ctrl

Overview:
- Registered CPU-side memory controller for the Aliens core.
- Holds the CPU bankswitch register (bank, WOCO, INIT) and decodes the CPU address map into chip selects.
- Sequences program/bank ROM reads over a req/ack port to external ROM storage (SDRAM/BRAM), stalling the CPU with cpu_wait.
- A single-entry last-read cache skips repeated fetches.

Parameters:
- TIMEOUT, 64: max cycles waiting for rom_ack before a forced release.
- CACHE_EN, 1: 1 enables the single-entry read cache; 0 makes every ROM read fetch.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- cpu_addr in 16: CPU address.
- cpu_as_n in 1: address strobe, active low.
- cpu_rw in 1: 1 = read.
- setlines_we in 1: one-cycle bankswitch register write strobe.
- setlines_d in 8: [4:0] bank, [5] woco, [6] init.
- cs_work, cs_pal, cs_bank, cs_prog, cs_vid, cs_io, cs_init out 1 each: registered active-high selects.
- cpu_wait out 1: stall CPU.
- rom_req out 1, rom_ack in 1: fetch handshake.
- rom_chip out 1: 0 = PROG ROM, 1 = BANK ROM.
- rom_addr out 18: fetch address.
- rom_data in 8: fetch data, valid with rom_ack.
- rom_dout out 8: byte returned to CPU.
- rom_err out 1: one-cycle timeout pulse.

Behaviour:
- Reset values:
  - bank = 0, woco = 0, init = 0.
  - All cs_* = 0; cpu_wait, rom_req, rom_err = 0.
  - rom_addr = 0, rom_chip = 0, rom_dout = 8'hFF.
  - Cache invalid; state IDLE.
  - Reset mid-fetch drops rom_req on the next edge.
- Register: setlines_we loads the register at the edge and is accepted in any state. A fetch already in flight keeps its latched rom_addr/rom_chip.
- Decode, with A = latched address; bk4 = bank[4]:
  - pal: A[15:10] = 0 & woco.
  - work: (A[15:10] = 0 & !woco) | A[15:10] in 1..7.
  - bank: A[15:13] = 001 & !bk4.
  - prog: A[15] | (A[15:13] = 001 & bk4).
  - vid: A[15:14] = 01.
  - io: A[15:10] = 010111; overlaps vid, and both assert.
- cs_init = init & A[15:11] = 01111, using the live cpu_addr. It is registered every cycle, independent of AS.
- ROM address:
  - Fixed prog (A[15] = 1): {3'b000, A[14:0]}, chip 0.
  - Banked with bk4 = 1: {1'b1, bank[3:0], A[12:0]}, chip 0.
  - Banked with bk4 = 0: {1'b0, bank[3:0], A[12:0]}, chip 1.
- FSM states IDLE, ROM_WAIT, HOLD.
- IDLE, cpu_as_n sampled 0:
  - Latch the address.
  - Assert the selected cs_* on the next cycle (1-cycle latency).
- IDLE branch for a ROM read (bank or prog, rw = 1):
  - Cache hit (CACHE_EN, valid, tag = {chip, addr}): rom_dout = cached byte, cpu_wait stays 0, go to HOLD.
  - Miss: rom_req = 1 and cpu_wait = 1 in the same cycle the cs asserts, then go to ROM_WAIT.
- IDLE branch for any other access, including ROM-region writes: no request, no wait, go to HOLD. The cache is untouched.
- ROM_WAIT:
  - rom_req stays high until rom_ack is sampled 1.
  - On ack: rom_dout = rom_data, cache loaded, rom_req = 0 and cpu_wait = 0 at the next edge, go to HOLD.
  - Timeout counter starts at 0 on entry. At count = TIMEOUT-1 with no ack:
    - rom_req = 0, cpu_wait = 0, rom_dout = 8'hFF, rom_err pulses 1 cycle.
    - Cache is not updated; go to HOLD.
    - A late ack arriving in HOLD/IDLE is ignored.
  - cpu_as_n rising during ROM_WAIT: the handshake still completes and the cache is loaded. Then go straight to IDLE, with the cs_* deasserted.
- HOLD: cs_* held while cpu_as_n = 0. When cpu_as_n = 1, go to IDLE, with all cs_* except cs_init cleared on the next cycle.
- Back-to-back: a new AS low is only recognised in IDLE. The minimum gap is one cycle with AS high.

Decomposition:
- Shared package aliens_pkg:
  - FSM state encoding.
  - Region base constants (PAL 0x0000, WORK_END 0x1FFF, BANKWIN 0x2000, VID 0x4000, IO 0x5C00, INIT 0x7800, PROG 0x8000).
  - Setlines bit indices.
- One sub-module, aliens_addr_decode: purely combinational region decode plus ROM address/chip formation from (addr, bank, woco, init).
- The FSM, register and cache stay in the top module.

Test Plan:
- Reset, then setlines_d = 8'h25 (bank 5, woco 1). Read 0x0010 -> cs_pal = 1 one cycle after AS low, cs_work = 0, no rom_req.
- Bank 8'h03, read 0x2ABC -> cs_bank = 1, rom_chip = 1, rom_addr = 18'h06ABC. Ack after 5 cycles with 8'h5A -> cpu_wait high 5 cycles, rom_dout = 8'h5A.
- Same read repeated -> cache hit: no rom_req, cpu_wait = 0, rom_dout = 8'h5A. Then setlines bank 8'h13, read 0x2ABC -> rom_chip = 0, rom_addr = 18'h26ABC, fetch issued.
- Read 0x8001 with rom_ack never asserted -> rom_req drops after 64 cycles, rom_err pulses once, rom_dout = 8'hFF. A following read of 0x8001 refetches.
- Read 0x5C20 -> cs_io = cs_vid = 1. Init = 1, address 0x7900 with AS high -> cs_init = 1.
- Reset asserted during ROM_WAIT -> next edge: rom_req = 0, cpu_wait = 0, all cs_* = 0. Re-read of the same address fetches (cache invalid).
